// File: rtl/ln_pkg.sv
// Shared types and width helpers for the streaming LayerNorm/RMSNorm statistics engine.
package ln_pkg;

  typedef enum logic [1:0] {ACC, MEAN, VAR, DONE} ln_state_e;

  // Default geometry of the SFU instance.
  localparam int DEF_DIM_SIZE   = 128;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LANES      = 8;
  localparam int DEF_FRAC_BITS  = 8;

  function automatic int beats(input int dim, input int lanes);
    return dim / lanes;
  endfunction

  function automatic int log2d(input int dim);
    return $clog2(dim);
  endfunction

  // A full vector of lane values never overflows these widths.
  function automatic int sum_width(input int dw, input int dim);
    return dw + $clog2(dim);
  endfunction

  function automatic int sumsq_width(input int dw, input int dim);
    return 2 * dw + $clog2(dim);
  endfunction

  // Keep the beat counter at least one bit wide when a vector is a single beat.
  function automatic int cnt_width(input int b);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

  // Clamp a signed value into the signed range of 'width' bits (width < 64).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/ln_stat_acc.sv
// Lane adder tree for sum and sum-of-squares feeding the two vector accumulators.
module ln_lane_sq import ln_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int SUM_W      = 23,
  parameter int SQ_W       = 39
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [SUM_W-1:0]      ext,
  output logic        [SQ_W-1:0]       sq
);
  logic signed [2*DATA_WIDTH-1:0] prod;

  // Square is always non-negative, even for the most negative input.
  assign prod = x * x;
  assign ext  = {{(SUM_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
  assign sq   = {{(SQ_W-2*DATA_WIDTH){1'b0}}, prod};
endmodule

module ln_stat_acc import ln_pkg::*; #(
  parameter int DIM_SIZE   = 128,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            acc_en,
  input  logic                                            acc_load,
  input  logic signed [DATA_WIDTH-1:0]                    lane_data [LANES],
  output logic signed [sum_width(DATA_WIDTH,DIM_SIZE)-1:0] sum,
  output logic        [sumsq_width(DATA_WIDTH,DIM_SIZE)-1:0] sumsq
);
  localparam int SUM_W = sum_width(DATA_WIDTH, DIM_SIZE);
  localparam int SQ_W  = sumsq_width(DATA_WIDTH, DIM_SIZE);

  logic signed [SUM_W-1:0] ext   [LANES];
  logic        [SQ_W-1:0]  sq    [LANES];
  logic signed [SUM_W-1:0] beat_sum;
  logic        [SQ_W-1:0]  beat_sq;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ln_lane_sq #(.DATA_WIDTH(DATA_WIDTH), .SUM_W(SUM_W), .SQ_W(SQ_W)) u_lane (
      .x   (lane_data[l]),
      .ext (ext[l]),
      .sq  (sq[l])
    );
  end

  // Reduce the lanes of one beat; synthesis balances the chain into a tree.
  always_comb begin
    beat_sum = '0;
    beat_sq  = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + ext[l];
      beat_sq  = beat_sq + sq[l];
    end
  end

  // First beat of a vector overwrites the accumulators, later beats add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum   <= '0;
      sumsq <= '0;
    end else if (acc_en) begin
      sum   <= acc_load ? beat_sum : sum + beat_sum;
      sumsq <= acc_load ? beat_sq  : sumsq + beat_sq;
    end
  end
endmodule

// File: rtl/layernorm_stream.sv
// Streaming LayerNorm/RMSNorm statistics: accumulate a vector, then emit mean, variance, gamma*variance.
module layernorm_stream import ln_pkg::*; #(
  parameter int DIM_SIZE   = DEF_DIM_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_rms_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data [LANES],
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] gmma,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_mean,
  output logic signed [DATA_WIDTH-1:0] out_var,
  output logic signed [DATA_WIDTH-1:0] out_var_gmma,
  output logic                         err_len
);
  localparam int BEATS = beats(DIM_SIZE, LANES);
  localparam int LOG2D = log2d(DIM_SIZE);
  localparam int SUM_W = sum_width(DATA_WIDTH, DIM_SIZE);
  localparam int SQ_W  = sumsq_width(DATA_WIDTH, DIM_SIZE);
  localparam int CNT_W = cnt_width(BEATS);
  localparam int P_W   = 2 * DATA_WIDTH;

  ln_state_e                  state;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       rms_r;
  logic signed [DATA_WIDTH-1:0] gmma_r;
  logic signed [DATA_WIDTH-1:0] mean_r;
  logic [P_W-1:0]             msq_r;
  logic [P_W-1:0]             ex2_r;

  logic                       fire;
  logic                       last_beat;
  logic signed [SUM_W-1:0]    sum;
  logic [SQ_W-1:0]            sumsq;

  logic signed [DATA_WIDTH-1:0] mean_c;
  logic signed [P_W-1:0]        msq_c;
  logic [P_W-1:0]               ex2_c;
  logic signed [63:0]           d_c;
  logic signed [63:0]           var_full;
  logic signed [DATA_WIDTH-1:0] var_c;
  logic signed [63:0]           vg_full;
  logic signed [DATA_WIDTH-1:0] vg_c;
  logic                         unused_bits;

  assign fire      = in_valid && in_ready;
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  ln_stat_acc #(.DIM_SIZE(DIM_SIZE), .DATA_WIDTH(DATA_WIDTH), .LANES(LANES)) u_acc (
    .clk       (clk),
    .rst       (rst),
    .acc_en    (fire),
    .acc_load  (beat_cnt == '0),
    .lane_data (in_data),
    .sum       (sum),
    .sumsq     (sumsq)
  );

  // MEAN stage math: dropping the low LOG2D bits is the floor divide by DIM_SIZE.
  always_comb begin
    mean_c = $signed(sum[LOG2D +: DATA_WIDTH]);
    msq_c  = mean_c * mean_c;
    ex2_c  = sumsq[LOG2D +: P_W];
  end

  // VAR stage math: clamp the difference at zero, scale out of Q(2F), saturate both results.
  always_comb begin
    d_c = $signed({{(64-P_W){1'b0}}, ex2_r}) - $signed({{(64-P_W){1'b0}}, msq_r});
    if (d_c < 0) d_c = '0;
    var_full = sat_signed(d_c >>> FRAC_BITS, DATA_WIDTH);
    var_c    = var_full[DATA_WIDTH-1:0];
    vg_full  = sat_signed(($signed({{(64-DATA_WIDTH){1'b0}}, var_c}) *
                           $signed({{(64-DATA_WIDTH){gmma_r[DATA_WIDTH-1]}}, gmma_r})) >>> FRAC_BITS,
                          DATA_WIDTH);
    vg_c     = vg_full[DATA_WIDTH-1:0];
  end

  // Truncated fractions and the saturated-away upper bits are intentionally dropped.
  assign unused_bits = ^{sum[LOG2D-1:0], sumsq[LOG2D-1:0],
                         var_full[63:DATA_WIDTH], vg_full[63:DATA_WIDTH]};

  // Sequencer with registered handshakes, stage registers and the sticky length check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ACC;
      beat_cnt     <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      rms_r        <= 1'b0;
      gmma_r       <= '0;
      mean_r       <= '0;
      msq_r        <= '0;
      ex2_r        <= '0;
      out_mean     <= '0;
      out_var      <= '0;
      out_var_gmma <= '0;
      err_len      <= 1'b0;
    end else begin
      case (state)
        ACC: if (fire) begin
          if (beat_cnt == '0) rms_r <= cfg_rms_mode;
          if (in_last != last_beat) err_len <= 1'b1;
          if (last_beat) begin
            beat_cnt <= '0;
            gmma_r   <= gmma;
            in_ready <= 1'b0;
            state    <= MEAN;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        MEAN: begin
          mean_r <= rms_r ? '0 : mean_c;
          msq_r  <= rms_r ? '0 : P_W'(msq_c);
          ex2_r  <= ex2_c;
          state  <= VAR;
        end
        VAR: begin
          out_mean     <= mean_r;
          out_var      <= var_c;
          out_var_gmma <= vg_c;
          out_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          beat_cnt  <= '0;
          state     <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_layernorm_stream.sv
// Directed bench for layernorm_stream with hand-computed statistics.
module tb_layernorm_stream;
  localparam int DIM   = 128;
  localparam int DW    = 16;
  localparam int LN    = 8;
  localparam int FB    = 8;
  localparam int BEATS = DIM / LN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_rms_mode = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [DW-1:0] in_data [LN];
  logic in_last = 1'b0;
  logic signed [DW-1:0] gmma = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [DW-1:0] out_mean, out_var, out_var_gmma;
  logic err_len;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  layernorm_stream #(.DIM_SIZE(DIM), .DATA_WIDTH(DW), .LANES(LN), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .cfg_rms_mode(cfg_rms_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .gmma(gmma), .out_valid(out_valid), .out_ready(out_ready),
    .out_mean(out_mean), .out_var(out_var), .out_var_gmma(out_var_gmma), .err_len(err_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive nbeats beats: even elements a, odd elements b. The mode bit is only correct on
  // beat 0 and gamma only on beat BEATS-1, so wrong sampling points corrupt the result.
  task automatic drive_vec(input int a, input int b, input logic rms, input int g,
                           input bit gaps, input int last_at, input int nbeats,
                           output int last_cyc);
    last_cyc = 0;
    for (int bt = 0; bt < nbeats; bt++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 3);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
      end
      for (int l = 0; l < LN; l++) in_data[l] = (l % 2 == 0) ? DW'(a) : DW'(b);
      in_last      = (bt == last_at);
      cfg_rms_mode = (bt == 0) ? rms : ~rms;
      gmma         = (bt == BEATS - 1) ? DW'(g) : DW'($urandom_range(0, 65535));
      in_valid     = 1'b1;
      begin
        int t;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL in_ready_timeout beat=%0d", bt); end
      end
      @(posedge clk);
      @(negedge clk);
      last_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int rise_cyc);
    int t;
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL out_valid_timeout"); end
    rise_cyc = cyc;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_mean !== 16'sd0) begin errors++; $display("FAIL reset_mean got=%0d exp=0", out_mean); end
    checks++; if (out_var !== 16'sd0)  begin errors++; $display("FAIL reset_var got=%0d exp=0", out_var); end
    checks++; if (out_var_gmma !== 16'sd0) begin errors++; $display("FAIL reset_vg got=%0d exp=0", out_var_gmma); end
    checks++; if (err_len !== 1'b0)    begin errors++; $display("FAIL reset_err got=%b exp=0", err_len); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ln_const();
    int lc, rc;
    drive_vec(256, 256, 1'b0, 256, 1'b0, BEATS - 1, BEATS, lc);
    wait_out(rc);
    checks++; if (rc - lc !== 2) begin errors++; $display("FAIL ln_const_latency got=%0d exp=2", rc - lc); end
    checks++; if (out_mean !== 16'sd256) begin errors++; $display("FAIL ln_const_mean got=%0d exp=256", out_mean); end
    checks++; if (out_var !== 16'sd0) begin errors++; $display("FAIL ln_const_var got=%0d exp=0", out_var); end
    checks++; if (out_var_gmma !== 16'sd0) begin errors++; $display("FAIL ln_const_vg got=%0d exp=0", out_var_gmma); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL ln_const_err got=%b exp=0", err_len); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ln_const_in_ready_done got=%b exp=0", in_ready); end
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL ln_const_handshake got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_ln_alt();
    int lc, rc;
    drive_vec(512, -512, 1'b0, 128, 1'b0, BEATS - 1, BEATS, lc);
    wait_out(rc);
    checks++; if (out_mean !== 16'sd0) begin errors++; $display("FAIL ln_alt_mean got=%0d exp=0", out_mean); end
    checks++; if (out_var !== 16'sd1024) begin errors++; $display("FAIL ln_alt_var got=%0d exp=1024", out_var); end
    checks++; if (out_var_gmma !== 16'sd512) begin errors++; $display("FAIL ln_alt_vg got=%0d exp=512", out_var_gmma); end
    handshake();
  endtask

  task automatic test_rms_const();
    int lc, rc;
    drive_vec(768, 768, 1'b1, 256, 1'b0, BEATS - 1, BEATS, lc);
    wait_out(rc);
    checks++; if (out_mean !== 16'sd0) begin errors++; $display("FAIL rms_const_mean got=%0d exp=0", out_mean); end
    checks++; if (out_var !== 16'sd2304) begin errors++; $display("FAIL rms_const_var got=%0d exp=2304", out_var); end
    checks++; if (out_var_gmma !== 16'sd2304) begin errors++; $display("FAIL rms_const_vg got=%0d exp=2304", out_var_gmma); end
    handshake();
  endtask

  task automatic test_rms_sat();
    int lc, rc;
    drive_vec(32767, 32767, 1'b1, 32767, 1'b0, BEATS - 1, BEATS, lc);
    wait_out(rc);
    checks++; if (out_mean !== 16'sd0) begin errors++; $display("FAIL rms_sat_mean got=%0d exp=0", out_mean); end
    checks++; if (out_var !== 16'sd32767) begin errors++; $display("FAIL rms_sat_var got=%0d exp=32767", out_var); end
    checks++; if (out_var_gmma !== 16'sd32767) begin errors++; $display("FAIL rms_sat_vg got=%0d exp=32767", out_var_gmma); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lc, rc;
    // 768/-768: mean 0, E[x^2] = 768^2 -> var 2304.
    drive_vec(768, -768, 1'b0, 256, 1'b1, BEATS - 1, BEATS, lc);
    wait_out(rc);
    checks++; if (rc - lc !== 2) begin errors++; $display("FAIL bp_latency got=%0d exp=2", rc - lc); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mean !== 16'sd0 ||
          out_var !== 16'sd2304 || out_var_gmma !== 16'sd2304)
        begin errors++; $display("FAIL bp_hold cyc=%0d got v=%b r=%b m=%0d var=%0d vg=%0d exp v=1 r=0 m=0 var=2304 vg=2304",
                                 i, out_valid, in_ready, out_mean, out_var, out_var_gmma); end
    end
    handshake();
    // 768/256, gamma -1.0: mean 512, E[x^2]=327680, msq=262144 -> var 256, vg -256.
    drive_vec(768, 256, 1'b0, -256, 1'b1, BEATS - 1, BEATS, lc);
    wait_out(rc);
    checks++; if (out_mean !== 16'sd512) begin errors++; $display("FAIL b2b_mean got=%0d exp=512", out_mean); end
    checks++; if (out_var !== 16'sd256) begin errors++; $display("FAIL b2b_var got=%0d exp=256", out_var); end
    checks++; if (out_var_gmma !== -16'sd256) begin errors++; $display("FAIL b2b_vg got=%0d exp=-256", out_var_gmma); end
    handshake();
  endtask

  task automatic test_len_err();
    int lc, rc;
    drive_vec(256, 256, 1'b0, 256, 1'b0, 5, 5, lc);
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL len_err_early got=%b exp=0", err_len); end
    drive_vec(256, 256, 1'b0, 256, 1'b0, 0, 1, lc);
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL len_err_set got=%b exp=1", err_len); end
    in_last = 1'b0;
    // Remaining beats 6..15 with no in_last at all; drive_vec's beat index restarts so last_at=-1.
    for (int bt = 6; bt < BEATS; bt++) begin
      for (int l = 0; l < LN; l++) in_data[l] = 16'sd256;
      gmma = (bt == BEATS - 1) ? 16'sd256 : 16'sd0;
      cfg_rms_mode = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (bt < BEATS - 1 && out_valid !== 1'b0)
        begin errors++; $display("FAIL len_err_early_out beat=%0d got=%b exp=0", bt, out_valid); end
    end
    in_valid = 1'b0;
    wait_out(rc);
    checks++; if (out_mean !== 16'sd256) begin errors++; $display("FAIL len_err_mean got=%0d exp=256", out_mean); end
    checks++; if (out_var !== 16'sd0) begin errors++; $display("FAIL len_err_var got=%0d exp=0", out_var); end
    handshake();
    drive_vec(512, -512, 1'b0, 128, 1'b0, BEATS - 1, BEATS, lc);
    wait_out(rc);
    checks++; if (out_var_gmma !== 16'sd512) begin errors++; $display("FAIL len_err_next_vg got=%0d exp=512", out_var_gmma); end
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL len_err_sticky got=%b exp=1", err_len); end
  endtask

  task automatic test_mid_reset();
    int lc, rc;
    // Pending result from the previous task is still in DONE; the next vector goes in after it.
    handshake();
    drive_vec(1000, 1000, 1'b0, 256, 1'b0, BEATS - 1, 9, lc);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_mean !== 16'sd0 || out_var !== 16'sd0 || out_var_gmma !== 16'sd0)
      begin errors++; $display("FAIL mid_reset_outs got m=%0d var=%0d vg=%0d exp 0 0 0", out_mean, out_var, out_var_gmma); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_len !== 1'b0)
      begin errors++; $display("FAIL mid_reset_ctrl got v=%b r=%b e=%b exp v=0 r=1 e=0", out_valid, in_ready, err_len); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive_vec(512, -512, 1'b0, 128, 1'b0, BEATS - 1, BEATS, lc);
    wait_out(rc);
    checks++; if (rc - lc !== 2) begin errors++; $display("FAIL mid_reset_latency got=%0d exp=2", rc - lc); end
    checks++; if (out_mean !== 16'sd0) begin errors++; $display("FAIL mid_reset_mean got=%0d exp=0", out_mean); end
    checks++; if (out_var !== 16'sd1024) begin errors++; $display("FAIL mid_reset_var got=%0d exp=1024", out_var); end
    checks++; if (out_var_gmma !== 16'sd512) begin errors++; $display("FAIL mid_reset_vg got=%0d exp=512", out_var_gmma); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL mid_reset_err got=%b exp=0", err_len); end
    handshake();
  endtask

  initial begin
    for (int l = 0; l < LN; l++) in_data[l] = '0;
    test_reset();
    test_ln_const();
    test_ln_alt();
    test_rms_const();
    test_rms_sat();
    test_back_to_back();
    test_len_err();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
